// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
// MAX_DIGITS bounds the digit count that is_leading_blank can inspect.
package display_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 16;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // True when digit `index` and every more-significant digit are zero.
  // Digit 0 is never treated as a leading zero.
  function automatic logic is_leading_blank(input logic [DIGIT_W*MAX_DIGITS-1:0] value,
                                            input int index);
    logic blank;
    blank = (index > 0);
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i >= index && value[i*DIGIT_W +: DIGIT_W] != '0) blank = 1'b0;
    end
    return blank;
  endfunction

endpackage

// File: rtl/display_prescaler.sv
// Slot prescaler: counts 0..SCAN_DIV-1 and flags the last cycle of a slot.
// Exposes the next count so the parent can register outputs aligned with it.
module display_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(SCAN_DIV)-1:0] k_next,
  output logic                        slot_end
);

  localparam int KW = $clog2(SCAN_DIV);

  logic [KW-1:0] k;

  always_comb begin
    slot_end = (k == KW'(SCAN_DIV - 1));
    k_next   = slot_end ? '0 : k + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= '0;
    else        k <= k_next;
  end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed BCD digit scanner feeding an external 7-segment decoder.
// Loads are shadowed and committed only at frame boundaries to avoid tearing.
module display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int DEAD_CYCLES   = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value_in,
  output logic                          load_ack,
  output logic [DIGIT_W-1:0]            data,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic                          frame_tick
);

  localparam int KW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = DIGIT_W * NUM_DIGITS;

  logic [KW-1:0]                 k_next;
  logic                          slot_end;
  logic [IW-1:0]                 idx, idx_next;
  logic [VW-1:0]                 shadow, shadow_next;
  logic [VW-1:0]                 active, active_next;
  logic                          pending, pending_next;
  logic                          commit;
  logic [DIGIT_W*MAX_DIGITS-1:0] active_ext;
  bcd_t                          nib_next;
  logic                          blank_next;
  logic [NUM_DIGITS-1:0]         en_next;
  logic                          ft_next;

  display_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .k_next   (k_next),
    .slot_end (slot_end)
  );

  // Slot index and load/commit bookkeeping. A load in the frame's final cycle
  // bypasses the shadow so the newest value still makes this frame boundary.
  always_comb begin
    idx_next = idx;
    if (slot_end) idx_next = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

    commit       = slot_end && (idx == IW'(NUM_DIGITS - 1)) && (pending || load);
    shadow_next  = load ? value_in : shadow;
    active_next  = commit ? (load ? value_in : shadow) : active;
    pending_next = commit ? 1'b0 : (load ? 1'b1 : pending);
  end

  // Outputs are computed from next state so the registered values line up
  // with the slot and prescaler position they describe.
  always_comb begin
    active_ext          = '0;
    active_ext[VW-1:0]  = active_next;
    nib_next            = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IW'(i)) nib_next = active_next[i*DIGIT_W +: DIGIT_W];
    end
    blank_next = (nib_next > BCD_MAX) ||
                 ((BLANK_LEADING != 0) && is_leading_blank(active_ext, int'(idx_next)));
    en_next = '0;
    if (k_next >= KW'(DEAD_CYCLES) && !blank_next) en_next = NUM_DIGITS'(1) << idx_next;
    ft_next = (idx_next == IW'(NUM_DIGITS - 1)) && (k_next == KW'(SCAN_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      data       <= '0;
      digit_en   <= '0;
      frame_tick <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      idx        <= idx_next;
      shadow     <= shadow_next;
      active     <= active_next;
      pending    <= pending_next;
      data       <= nib_next;
      digit_en   <= en_next;
      frame_tick <= ft_next;
      load_ack   <= commit;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: a frame-level reference model checked
// every cycle, a table of display patterns, and hand-written corner sequences.
module tb_display_scan;

  localparam int N    = 4;
  localparam int DIV  = 8;
  localparam int DEAD = 2;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        load     = 1'b0;
  logic [15:0] value_in = '0;
  logic        load_ack, frame_tick;
  logic [3:0]  data, digit_en;
  logic        ack_nb, ft_nb;
  logic [3:0]  data_nb, en_nb;

  always #5 clk = ~clk;

  display_scan #(
    .NUM_DIGITS(N), .SCAN_DIV(DIV), .DEAD_CYCLES(DEAD), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .load_ack(load_ack), .data(data), .digit_en(digit_en), .frame_tick(frame_tick)
  );

  display_scan #(
    .NUM_DIGITS(N), .SCAN_DIV(DIV), .DEAD_CYCLES(DEAD), .BLANK_LEADING(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .load_ack(ack_nb), .data(data_nb), .digit_en(en_nb), .frame_tick(ft_nb)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: time since reset plus the displayed/queued values.
  int          cyc;
  logic [15:0] m_active, m_shadow;
  bit          m_pending, m_ack;
  int          ack_count, ft_count;

  typedef struct {
    logic [15:0] value;
    logic [15:0] en_bl;
    logic [15:0] en_all;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_en(input logic [15:0] val, input int slot,
                                        input int k, input bit bl);
    int         sig;
    logic [3:0] nib;
    sig = 1;
    for (int i = 0; i < N; i++) if (val[i*4 +: 4] != 4'd0) sig = i + 1;
    nib = val[slot*4 +: 4];
    if (k < DEAD || nib > 4'd9 || (bl && slot >= sig)) return 4'b0000;
    return 4'(1 << slot);
  endfunction

  task automatic model_reset();
    cyc = 0; m_active = '0; m_shadow = '0; m_pending = 0; m_ack = 0;
    ack_count = 0; ft_count = 0;
  endtask

  task automatic model_step(input bit ld, input logic [15:0] v);
    bit frame;
    frame = ((cyc / DIV) % N == N - 1) && (cyc % DIV == DIV - 1);
    if (ld) begin m_shadow = v; m_pending = 1; end
    m_ack = 0;
    if (frame && m_pending) begin m_active = m_shadow; m_pending = 0; m_ack = 1; end
    cyc++;
  endtask

  task automatic apply_stimulus(input bit ld, input logic [15:0] v);
    load = ld; value_in = v;
  endtask

  task automatic check_output();
    int slot, k;
    slot = (cyc / DIV) % N;
    k    = cyc % DIV;
    check("data",        data,       m_active[slot*4 +: 4]);
    check("digit_en",    digit_en,   exp_en(m_active, slot, k, 1));
    check("load_ack",    load_ack,   m_ack);
    check("frame_tick",  frame_tick, (slot == N - 1) && (k == DIV - 1));
    check("data_nb",     data_nb,    m_active[slot*4 +: 4]);
    check("digit_en_nb", en_nb,      exp_en(m_active, slot, k, 0));
    check("load_ack_nb", ack_nb,     m_ack);
    if (load_ack === 1'b1) ack_count++;
    if (frame_tick === 1'b1) ft_count++;
  endtask

  // One clock: drive at the falling edge, compare, then advance the model.
  task automatic step(input bit ld, input logic [15:0] v);
    apply_stimulus(ld, v);
    check_output();
    @(posedge clk);
    model_step(ld, v);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    check("rst_data",     data,       0);
    check("rst_digit_en", digit_en,   0);
    check("rst_load_ack", load_ack,   0);
    check("rst_frame",    frame_tick, 0);
    check("rst_en_nb",    en_nb,      0);
    @(negedge clk);
    @(negedge clk);
    apply_stimulus(0, '0);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_stimulus(0, '0);
    assert_reset();
  endtask

  initial begin
    bit          seen;
    logic [15:0] v;

    vecs[0] = '{16'h1234, 16'h8421, 16'h8421};
    vecs[1] = '{16'h0070, 16'h0021, 16'h8421};
    vecs[2] = '{16'h12A4, 16'h8401, 16'h8401};
    vecs[3] = '{16'hF000, 16'h0421, 16'h0421};
    vecs[4] = '{16'h0000, 16'h0001, 16'h8421};
    vecs[5] = '{16'h0305, 16'h0421, 16'h8421};

    // Idle frame after reset: only digit 0 lights, frame_tick at cycle 31.
    do_reset();
    for (int c = 0; c < 32; c++) begin
      if (c == 1)  check("idle_dead_c1", digit_en, 4'b0000);
      if (c == 2)  check("idle_show_c2", digit_en, 4'b0001);
      if (c == 31) begin
        check("ft_none_before_31", ft_count, 0);
        check("ft_at_31", frame_tick, 1);
      end
      step(0, '0);
    end

    // Single load mid-frame, acknowledged at the frame boundary.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c == 32) check("ack_at_32", load_ack, 1);
      step(c == 5, 16'h1234);
    end
    check("ack_count_single", ack_count, 1);

    // Table of display patterns, sampled mid-slot after commit.
    do_reset();
    foreach (vecs[n]) begin
      step(1, vecs[n].value);
      seen = 0;
      for (int t = 0; t < N * DIV + 2 && !seen; t++) begin
        if (load_ack === 1'b1) seen = 1;
        else step(0, '0);
      end
      check("table_ack_seen", seen, 1);
      for (int t = 0; t < N * DIV; t++) begin
        if (cyc % DIV == 4) begin
          check("table_data",   data,    vecs[n].value[((cyc / DIV) % N)*4 +: 4]);
          check("table_en",     digit_en, vecs[n].en_bl[((cyc / DIV) % N)*4 +: 4]);
          check("table_en_nb",  en_nb,   vecs[n].en_all[((cyc / DIV) % N)*4 +: 4]);
        end
        step(0, '0);
      end
    end

    // Several loads in one frame, the last landing on the frame_tick cycle.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      if (c == 32) begin
        check("multi_ack_32", load_ack, 1);
        check("multi_data_32", data, 4'h3);
      end
      step(c == 10 || c == 20 || c == 31,
           (c == 10) ? 16'h1111 : (c == 20) ? 16'h2222 : 16'h3333);
    end
    check("multi_ack_count", ack_count, 1);

    // Randomized loads against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 5) == 0, v);
    end

    // Reset with a load pending drops it and clears the display immediately.
    do_reset();
    for (int c = 0; c < 41; c++) step(c == 1, 16'h9876);
    for (int c = 41; c < 47; c++) step(c == 41, 16'h5555);
    check("pre_reset_en", digit_en, 4'b0010);
    #2;
    assert_reset();
    for (int c = 0; c < 64; c++) step(0, '0);
    check("no_ack_after_reset", ack_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
